// File: rtl/game_flow_ctrl.sv
`timescale 1ns/1ps
// Game-flow sequencer: title screen, one-cycle level load, timed play with a
// door-hold win, death/win/over hold screens and a final finish screen.
module game_flow_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_LEVELS   = 4,
    parameter int LIVES        = 3,
    parameter int FRAMES_PER_S = 60,
    parameter int LEVEL_TIME_S = 180,
    parameter int DOOR_HOLD    = 30,
    parameter int DEATH_HOLD   = 90,
    localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_tick,
    input  logic                   confirm,
    input  logic [NUM_PLAYERS-1:0] player_dead,
    input  logic [NUM_PLAYERS-1:0] player_at_door,
    output logic [2:0]             state_o,
    output logic [LW-1:0]          level_o,
    output logic [3:0]             lives_o,
    output logic [7:0]             time_left_o,
    output logic                   revive_o,
    output logic                   play_en_o,
    output logic                   timeout_o
);

    localparam int FW = (FRAMES_PER_S > 1) ? $clog2(FRAMES_PER_S) : 1;
    localparam int DW = (DOOR_HOLD > 0) ? $clog2(DOOR_HOLD + 1) : 1;
    localparam int HW = (DEATH_HOLD > 0) ? $clog2(DEATH_HOLD + 1) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_S - 1);
    localparam logic [DW-1:0] DOOR_MAX   = DW'(DOOR_HOLD);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(DEATH_HOLD);
    localparam logic [LW-1:0] LEVEL_LAST = LW'(NUM_LEVELS - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam logic [7:0]    TIME_INIT  = 8'(LEVEL_TIME_S);

    typedef enum logic [2:0] {
        ST_TITLE  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_DEAD   = 3'd3,
        ST_WIN    = 3'd4,
        ST_OVER   = 3'd5,
        ST_FINISH = 3'd6
    } state_e;

    state_e          state_q,   state_d;
    logic [LW-1:0]   level_q,   level_d;
    logic [3:0]      lives_q,   lives_d;
    logic [7:0]      time_q,    time_d;
    logic [FW-1:0]   frame_q,   frame_d;
    logic [DW-1:0]   door_q,    door_d;
    logic [HW-1:0]   hold_q,    hold_d;
    logic            revive_q,  revive_d;
    logic            play_en_q, play_en_d;
    logic            timeout_q, timeout_d;
    logic            confirm_q;

    logic conf_edge;
    logic hold_full;
    logic any_dead;
    logic all_door;

    assign conf_edge = confirm & ~confirm_q;
    assign hold_full = (hold_q == HOLD_MAX);
    assign any_dead  = |player_dead;
    assign all_door  = &player_at_door;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        lives_d   = lives_q;
        time_d    = time_q;
        frame_d   = frame_q;
        door_d    = door_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_TITLE: begin
                if (conf_edge) begin
                    state_d = ST_LOAD;
                    level_d = '0;
                    lives_d = LIVES_INIT;
                end
            end

            ST_LOAD: begin
                time_d    = TIME_INIT;
                frame_d   = '0;
                door_d    = '0;
                timeout_d = 1'b0;
                state_d   = ST_PLAY;
            end

            ST_PLAY: begin
                if (frame_tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = '0;
                        if (time_q != 8'd0) begin
                            time_d = time_q - 8'd1;
                        end
                    end else begin
                        frame_d = frame_q + FW'(1);
                    end
                end

                // Any player leaving the door restarts the hold window at once.
                if (!all_door) begin
                    door_d = '0;
                end else if (frame_tick && (door_q != DOOR_MAX)) begin
                    door_d = door_q + DW'(1);
                end

                if (any_dead || (time_q == 8'd0)) begin
                    lives_d   = lives_q - 4'd1;
                    timeout_d = ~any_dead;
                    hold_d    = '0;
                    state_d   = (lives_q == 4'd1) ? ST_OVER : ST_DEAD;
                end else if (door_q == DOOR_MAX) begin
                    hold_d  = '0;
                    state_d = ST_WIN;
                end
            end

            ST_DEAD, ST_WIN, ST_OVER, ST_FINISH: begin
                if (frame_tick && !hold_full) begin
                    hold_d = hold_q + HW'(1);
                end

                // Acceptance looks at the pre-tick hold count.
                if (conf_edge && hold_full) begin
                    timeout_d = 1'b0;
                    case (state_q)
                        ST_DEAD: state_d = ST_LOAD;
                        ST_WIN: begin
                            if (level_q == LEVEL_LAST) begin
                                state_d = ST_FINISH;
                                hold_d  = HOLD_MAX;
                            end else begin
                                level_d = level_q + LW'(1);
                                state_d = ST_LOAD;
                            end
                        end
                        default: state_d = ST_TITLE;
                    endcase
                end
            end

            default: state_d = ST_TITLE;
        endcase

        revive_d  = (state_d == ST_LOAD);
        play_en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_TITLE;
            level_q   <= '0;
            lives_q   <= LIVES_INIT;
            time_q    <= TIME_INIT;
            frame_q   <= '0;
            door_q    <= '0;
            hold_q    <= '0;
            revive_q  <= 1'b0;
            play_en_q <= 1'b0;
            timeout_q <= 1'b0;
            confirm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            time_q    <= time_d;
            frame_q   <= frame_d;
            door_q    <= door_d;
            hold_q    <= hold_d;
            revive_q  <= revive_d;
            play_en_q <= play_en_d;
            timeout_q <= timeout_d;
            confirm_q <= confirm;
        end
    end

    assign state_o     = state_q;
    assign level_o     = level_q;
    assign lives_o     = lives_q;
    assign time_left_o = time_q;
    assign revive_o    = revive_q;
    assign play_en_o   = play_en_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
// Bench for game_flow_ctrl: table of start-up vectors plus scripted sequences for
// timer expiry, hold screens, door-hold win, game over, finish and async reset.
module tb_game_flow_ctrl;

    localparam int NP = 2;

    localparam logic [2:0] S_TITLE  = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_DEAD   = 3'd3;
    localparam logic [2:0] S_WIN    = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;
    localparam logic [7:0] T_FULL   = 8'd180;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic          confirm = 1'b0;
    logic [NP-1:0] player_dead = '0;
    logic [NP-1:0] player_at_door = '0;
    logic [2:0]    state_o;
    logic [1:0]    level_o;
    logic [3:0]    lives_o;
    logic [7:0]    time_left_o;
    logic          revive_o;
    logic          play_en_o;
    logic          timeout_o;

    game_flow_ctrl #(
        .NUM_PLAYERS (NP),
        .NUM_LEVELS  (4),
        .LIVES       (3),
        .FRAMES_PER_S(60),
        .LEVEL_TIME_S(180),
        .DOOR_HOLD   (30),
        .DEATH_HOLD  (90)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .confirm       (confirm),
        .player_dead   (player_dead),
        .player_at_door(player_at_door),
        .state_o       (state_o),
        .level_o       (level_o),
        .lives_o       (lives_o),
        .time_left_o   (time_left_o),
        .revive_o      (revive_o),
        .play_en_o     (play_en_o),
        .timeout_o     (timeout_o)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lvl;
        logic [3:0] lv;
        logic [7:0] tl;
        logic       rev;
        logic       pen;
        logic       tmo;
    } exp_t;

    typedef struct packed {
        logic       tk;
        logic       cf;
        logic [1:0] dd;
        logic [1:0] dr;
        exp_t       e;
    } vec_t;

    exp_t  sbq[$];
    string nmq[$];
    int    n_run  = 0;
    int    n_fail = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic [1:0] lvl,
                                input logic [3:0] lv, input logic [7:0] tl,
                                input logic rev, input logic pen, input logic tmo);
        exp_t e;
        e = {st, lvl, lv, tl, rev, pen, tmo};
        return e;
    endfunction

    task automatic sb_push(input string nm, input exp_t e);
        sbq.push_back(e);
        nmq.push_back(nm);
    endtask

    task automatic sb_check();
        exp_t  e;
        exp_t  a;
        string nm;
        n_run++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got no expectation queued, required one");
            return;
        end
        e  = sbq.pop_front();
        nm = nmq.pop_front();
        a  = {state_o, level_o, lives_o, time_left_o, revive_o, play_en_o, timeout_o};
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d lvl=%0d lives=%0d time=%0d rev=%b pen=%b tmo=%b, want st=%0d lvl=%0d lives=%0d time=%0d rev=%b pen=%b tmo=%b",
                     nm, a.st, a.lvl, a.lv, a.tl, a.rev, a.pen, a.tmo,
                     e.st, e.lvl, e.lv, e.tl, e.rev, e.pen, e.tmo);
        end
    endtask

    task automatic cyc(input logic tk, input logic cf, input logic [1:0] dd, input logic [1:0] dr);
        frame_tick     = tk;
        confirm        = cf;
        player_dead    = dd;
        player_at_door = dr;
        @(posedge Clk);
        #1;
    endtask

    task automatic step_exp(input logic tk, input logic cf, input logic [1:0] dd,
                            input logic [1:0] dr, input string nm, input exp_t e);
        sb_push(nm, e);
        cyc(tk, cf, dd, dr);
        sb_check();
    endtask

    task automatic ticks(input int n, input logic [1:0] dd, input logic [1:0] dr);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, dd, dr);
            cyc(1'b0, 1'b0, dd, dr);
        end
    endtask

    task automatic ticks_chk(input int n, input logic [1:0] dd, input logic [1:0] dr,
                             input string nm, input exp_t e);
        ticks(n - 1, dd, dr);
        cyc(1'b1, 1'b0, dd, dr);
        step_exp(1'b0, 1'b0, dd, dr, nm, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish within 2 ms, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = {1'b0, 1'b1, 2'b00, 2'b00, mk(S_LOAD, 2'd0, 4'd3, T_FULL, 1'b1, 1'b0, 1'b0)};
        vecs[1] = {1'b0, 1'b1, 2'b00, 2'b00, mk(S_PLAY, 2'd0, 4'd3, T_FULL, 1'b0, 1'b1, 1'b0)};
        vecs[2] = {1'b0, 1'b0, 2'b00, 2'b01, mk(S_PLAY, 2'd0, 4'd3, T_FULL, 1'b0, 1'b1, 1'b0)};
        vecs[3] = {1'b0, 1'b1, 2'b00, 2'b00, mk(S_PLAY, 2'd0, 4'd3, T_FULL, 1'b0, 1'b1, 1'b0)};
        vecs[4] = {1'b0, 1'b0, 2'b00, 2'b00, mk(S_PLAY, 2'd0, 4'd3, T_FULL, 1'b0, 1'b1, 1'b0)};

        repeat (2) @(posedge Clk);
        #1;
        sb_push("reset_state", mk(S_TITLE, 2'd0, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));
        sb_check();
        Reset_n = 1'b1;
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "title_idle",
                 mk(S_TITLE, 2'd0, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));

        // Start-up: title -> load (revive) -> play, confirm ignored while playing.
        for (int i = 0; i < 5; i++) begin
            step_exp(vecs[i].tk, vecs[i].cf, vecs[i].dd, vecs[i].dr,
                     $sformatf("vec%0d", i), vecs[i].e);
        end

        // Countdown and timer expiry.
        ticks_chk(60, 2'b00, 2'b00, "t2_one_second",
                  mk(S_PLAY, 2'd0, 4'd3, 8'd179, 1'b0, 1'b1, 1'b0));
        ticks(10739, 2'b00, 2'b00);
        step_exp(1'b1, 1'b0, 2'b00, 2'b00, "t2_time_zero",
                 mk(S_PLAY, 2'd0, 4'd3, 8'd0, 1'b0, 1'b1, 1'b0));
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "t2_timeout_dead",
                 mk(S_DEAD, 2'd0, 4'd2, 8'd0, 1'b0, 1'b0, 1'b1));

        // Hold screen: early confirm and confirm coinciding with the 90th tick are ignored.
        ticks(50, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "hold50_conf_ignored",
                 mk(S_DEAD, 2'd0, 4'd2, 8'd0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        ticks(39, 2'b00, 2'b00);
        step_exp(1'b1, 1'b1, 2'b00, 2'b00, "conf_uses_pre_tick_hold",
                 mk(S_DEAD, 2'd0, 4'd2, 8'd0, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "dead_revive_load",
                 mk(S_LOAD, 2'd0, 4'd2, 8'd0, 1'b1, 1'b0, 1'b0));
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "dead_replay",
                 mk(S_PLAY, 2'd0, 4'd2, T_FULL, 1'b0, 1'b1, 1'b0));

        // Door hold broken after 29 frames, then a full 30-frame hold wins.
        ticks(29, 2'b00, 2'b11);
        step_exp(1'b0, 1'b0, 2'b00, 2'b01, "t4_door_drop",
                 mk(S_PLAY, 2'd0, 4'd2, T_FULL, 1'b0, 1'b1, 1'b0));
        ticks_chk(29, 2'b00, 2'b11, "t4_29_no_win",
                  mk(S_PLAY, 2'd0, 4'd2, T_FULL, 1'b0, 1'b1, 1'b0));
        ticks_chk(1, 2'b00, 2'b11, "t4_win",
                  mk(S_WIN, 2'd0, 4'd2, T_FULL, 1'b0, 1'b0, 1'b0));
        ticks(90, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t4_next_level",
                 mk(S_LOAD, 2'd1, 4'd2, T_FULL, 1'b1, 1'b0, 1'b0));
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "t4_play_level1",
                 mk(S_PLAY, 2'd1, 4'd2, T_FULL, 1'b0, 1'b1, 1'b0));

        // Player death keeps the level.
        step_exp(1'b0, 1'b0, 2'b01, 2'b00, "t3_dead",
                 mk(S_DEAD, 2'd1, 4'd1, T_FULL, 1'b0, 1'b0, 1'b0));
        ticks(90, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t3_load_same_level",
                 mk(S_LOAD, 2'd1, 4'd1, T_FULL, 1'b1, 1'b0, 1'b0));
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "t3_play",
                 mk(S_PLAY, 2'd1, 4'd1, T_FULL, 1'b0, 1'b1, 1'b0));

        // Last life lost -> game over -> title -> fresh start.
        step_exp(1'b0, 1'b0, 2'b10, 2'b00, "t5_over",
                 mk(S_OVER, 2'd1, 4'd0, T_FULL, 1'b0, 1'b0, 1'b0));
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t5_over_early_conf",
                 mk(S_OVER, 2'd1, 4'd0, T_FULL, 1'b0, 1'b0, 1'b0));
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        ticks(90, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t5_title",
                 mk(S_TITLE, 2'd1, 4'd0, T_FULL, 1'b0, 1'b0, 1'b0));
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t5_restart",
                 mk(S_LOAD, 2'd0, 4'd3, T_FULL, 1'b1, 1'b0, 1'b0));

        // Death during the load cycle is ignored; sampled from the first play cycle.
        step_exp(1'b0, 1'b0, 2'b01, 2'b00, "t6_load_dead_ignored",
                 mk(S_PLAY, 2'd0, 4'd3, T_FULL, 1'b0, 1'b1, 1'b0));
        step_exp(1'b0, 1'b0, 2'b01, 2'b00, "t6_dead_first_play",
                 mk(S_DEAD, 2'd0, 4'd2, T_FULL, 1'b0, 1'b0, 1'b0));
        ticks(90, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t6_reload",
                 mk(S_LOAD, 2'd0, 4'd2, T_FULL, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 1'b0, 2'b00, 2'b00);

        // Death and completed door hold in the same cycle: death wins.
        ticks(29, 2'b00, 2'b11);
        step_exp(1'b1, 1'b0, 2'b00, 2'b11, "t6_door_full_still_play",
                 mk(S_PLAY, 2'd0, 4'd2, T_FULL, 1'b0, 1'b1, 1'b0));
        step_exp(1'b0, 1'b0, 2'b01, 2'b11, "t6_dead_beats_win",
                 mk(S_DEAD, 2'd0, 4'd1, T_FULL, 1'b0, 1'b0, 1'b0));
        ticks(90, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "t6_reload2",
                 mk(S_LOAD, 2'd0, 4'd1, T_FULL, 1'b1, 1'b0, 1'b0));
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "t6_play2",
                 mk(S_PLAY, 2'd0, 4'd1, T_FULL, 1'b0, 1'b1, 1'b0));

        // Asynchronous reset in the middle of play.
        ticks(5, 2'b00, 2'b00);
        Reset_n = 1'b0;
        #2;
        sb_push("t6_async_reset", mk(S_TITLE, 2'd0, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));
        sb_check();
        @(posedge Clk);
        #1;
        sb_push("t6_reset_held", mk(S_TITLE, 2'd0, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));
        sb_check();
        Reset_n = 1'b1;
        step_exp(1'b0, 1'b0, 2'b00, 2'b00, "t6_after_reset",
                 mk(S_TITLE, 2'd0, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));

        // Win every level; the last one goes to finish, which needs no hold.
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "fin_load0",
                 mk(S_LOAD, 2'd0, 4'd3, T_FULL, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        for (int lv = 0; lv < 4; lv++) begin
            ticks_chk(30, 2'b00, 2'b11, $sformatf("fin_win_l%0d", lv),
                      mk(S_WIN, 2'(lv), 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));
            ticks(90, 2'b00, 2'b00);
            if (lv < 3) begin
                step_exp(1'b0, 1'b1, 2'b00, 2'b00, $sformatf("fin_next_l%0d", lv + 1),
                         mk(S_LOAD, 2'(lv + 1), 4'd3, T_FULL, 1'b1, 1'b0, 1'b0));
                cyc(1'b0, 1'b0, 2'b00, 2'b00);
            end else begin
                step_exp(1'b0, 1'b1, 2'b00, 2'b00, "fin_finish",
                         mk(S_FINISH, 2'd3, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));
            end
        end
        cyc(1'b0, 1'b0, 2'b00, 2'b00);
        step_exp(1'b0, 1'b1, 2'b00, 2'b00, "fin_title_no_hold",
                 mk(S_TITLE, 2'd3, 4'd3, T_FULL, 1'b0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
